alu_pipe_param: RTL
===================

Name: alu_pipe_param

Overview:
- Parametrised, registered successor to the team's fixed-width ALU.
- Adds configurable operand width, split-arrival operand capture with a timeout, and multi-cycle multiply commands.
- Adds an explicit result-valid handshake.
- Sits behind the same driver/monitor interface style as the existing ALU, so benches reuse the transaction format with widened fields.

Parameters:
- WIDTH, 8, operand width in bits (≥4, power of two).
- CMD_W, 4, command field width.
- TIMEOUT, 16, cycles to wait for a missing second operand.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- CE  input  1  clock enable; 0 freezes all state.
- MODE  input  1  1 = arithmetic, 0 = logical.
- CMD  input  CMD_W  operation select.
- INP_VALID  input  2  bit0 = OPA valid, bit1 = OPB valid.
- OPA  input  WIDTH  operand A.
- OPB  input  WIDTH  operand B.
- CIN  input  1  carry in.
- RES  output  2*WIDTH  result, zero-extended.
- RES_VALID  output  1  one-cycle pulse when RES and flags update.
- COUT  output  1  carry/borrow out.
- OFLOW  output  1  signed overflow.
- G, E, L  output  1 each  compare flags.
- ERR  output  1  error flag.
- BUSY  output  1  operation in progress.

Behaviour:
- Reset (RST=0, asynchronous):
  - All outputs go to 0, FSM goes to IDLE, timeout counter clears.
  - Reset mid-operation aborts the operation; no result is emitted.
- CE=0: FSM, counter, captured operands and outputs all hold; RES_VALID is forced 0.
- Arithmetic commands (MODE=1):
  - 0 ADD, 1 SUB, 2 ADD+CIN, 3 SUB−CIN.
  - 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B.
  - 8 CMP.
  - 9 MUL_INC = (A+1)*(B+1).
  - 10 MUL_SHL = (A<<1)*B.
- Logical commands (MODE=0):
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT_A, 7 NOT_B.
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B.
  - 12 ROL A by B, 13 ROR A by B.
  - Logical results are WIDTH bits, zero-extended into RES.
- Operand requirements:
  - A-only commands (INC_A, DEC_A, NOT_A, SHx_A) need INP_VALID[0] only.
  - B-only commands need INP_VALID[1] only.
  - All other commands need both operands.
- FSM states: IDLE, WAIT, EXEC, MUL2.
- IDLE:
  - INP_VALID=00: no action.
  - Required operands all valid at edge k: capture them, go to EXEC.
  - Only one of two required operands valid: capture it plus CMD/MODE/CIN, clear the counter, go to WAIT.
- WAIT:
  - The missing operand's valid bit seen at an edge: capture it, go to EXEC.
  - New CMD/MODE values and the already-captured operand's valid bit are ignored.
  - The counter increments each enabled cycle.
  - After TIMEOUT cycles without the missing operand: go to IDLE with RES=0, ERR=1, RES_VALID=1 and all other flags 0.
- EXEC:
  - Single-cycle ops register the result at the next edge, so capture at edge k gives RES_VALID high after edge k+1, then return to IDLE.
  - MUL commands move to MUL2 and register the result one edge later, after edge k+2.
- BUSY is 1 in WAIT, EXEC and MUL2. Inputs other than the awaited operand are ignored while BUSY.
- Flags:
  - ADD/ADD+CIN: COUT = bit WIDTH of the sum.
  - SUB/SUB−CIN: COUT = borrow (A < B + CIN).
  - ADD/SUB: OFLOW = signed overflow of the WIDTH-bit result.
  - CMP: RES=0; exactly one of G (A>B), E (A==B), L (A<B) is 1.
  - All non-applicable flags are 0.
  - Flags update only with RES_VALID and hold otherwise.
- ERR conditions:
  - Unsupported CMD/MODE combination: RES=0.
  - ROL/ROR with any OPB bit at or above bit $clog2(WIDTH) set: ERR=1, rotation still performed by OPB[$clog2(WIDTH)-1:0].
- RES and flags hold their last value between RES_VALID pulses.

Test Plan:
- WIDTH=8, MODE=1 CMD=0 OPA=8'hFF OPB=8'h01 INP_VALID=11 → one cycle later RES=16'h0100, COUT=1, OFLOW=0, RES_VALID pulse of one cycle.
- MODE=1 CMD=9 OPA=3 OPB=4 → RES_VALID after edge k+2 with RES=20, BUSY=1 for two cycles.
- MODE=1 CMD=0 INP_VALID=01 OPA=5, then 3 idle cycles, then INP_VALID=10 OPB=7 → RES=12 one cycle after OPB is captured, ERR=0.
- MODE=1 CMD=1 INP_VALID=01 OPA=9, OPB never supplied → after 16 waiting cycles RES_VALID=1, ERR=1, RES=0, FSM back in IDLE.
- MODE=0 CMD=12 OPA=8'h81 OPB=8'h01 → RES=8'h03, ERR=0; repeat with OPB=8'h11 → RES=8'h03, ERR=1.
- Assert RST=0 mid-WAIT and mid-MUL2 → outputs 0 immediately with no clock; after release, MODE=1 CMD=8 OPA=OPB=8'h2A → E=1, G=L=0.

Source files
------------

// File: rtl/alu_pipe_param.sv
// Parametrised registered ALU: split-arrival operand capture with a timeout,
// single-cycle arithmetic/logic results and two-cycle multiply commands.
module alu_pipe_param #(
    parameter int WIDTH   = 8,
    parameter int CMD_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CE,
    input  logic               MODE,
    input  logic [CMD_W-1:0]   CMD,
    input  logic [1:0]         INP_VALID,
    input  logic [WIDTH-1:0]   OPA,
    input  logic [WIDTH-1:0]   OPB,
    input  logic               CIN,
    output logic [2*WIDTH-1:0] RES,
    output logic               RES_VALID,
    output logic               COUT,
    output logic               OFLOW,
    output logic               G,
    output logic               E,
    output logic               L,
    output logic               ERR,
    output logic               BUSY
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [WIDTH:0]   ONE  = (WIDTH + 1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_MUL2} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_opa, r_opb;
    logic [CMD_W-1:0]   r_cmd;
    logic               r_mode, r_cin, r_have_a;
    logic [WIDTH:0]     r_fa, r_fb;
    logic [2*WIDTH-1:0] r_res;
    logic               r_res_valid, r_cout, r_oflow, r_g, r_e, r_l, r_err;

    logic [1:0]         w_req;
    logic               w_all_in, w_partial, w_arrive;
    logic [WIDTH:0]     w_ext_a, w_ext_b, w_ext_cin, w_arith;
    logic [WIDTH-1:0]   w_log;
    logic [SH_W-1:0]    w_amt;
    logic [2*WIDTH-1:0] w_res, w_prod;
    logic               w_cout, w_oflow, w_g, w_e, w_l, w_err, w_is_mul;
    logic [WIDTH:0]     w_fa, w_fb;

    // Returns {need_b, need_a}; unsupported encodings wait for both operands.
    function automatic logic [1:0] req_ops(input logic mode, input logic [CMD_W-1:0] cmd);
        logic [1:0] req;
        req = 2'b11;
        if (mode) begin
            case (int'(cmd))
                4, 5:      req = 2'b01;
                6, 7:      req = 2'b10;
                default:   req = 2'b11;
            endcase
        end else begin
            case (int'(cmd))
                6, 8, 9:   req = 2'b01;
                7, 10, 11: req = 2'b10;
                default:   req = 2'b11;
            endcase
        end
        return req;
    endfunction

    assign w_req     = req_ops(MODE, CMD);
    assign w_all_in  = &(INP_VALID | ~w_req);
    assign w_partial = (w_req == 2'b11) && (^INP_VALID);
    assign w_arrive  = r_have_a ? INP_VALID[1] : INP_VALID[0];

    assign w_ext_a   = {1'b0, r_opa};
    assign w_ext_b   = {1'b0, r_opb};
    assign w_ext_cin = (WIDTH + 1)'(r_cin);
    assign w_amt     = r_opb[SH_W-1:0];
    assign w_prod    = (2*WIDTH)'(r_fa) * (2*WIDTH)'(r_fb);

    // NOTE: combinational logic uses blocking assignments and defaults every
    // output first, so intermediate values read later in the block are current
    // and no path can leave a latch behind.
    always_comb begin
        w_arith  = '0;
        w_log    = '0;
        w_res    = '0;
        w_cout   = 1'b0;
        w_oflow  = 1'b0;
        w_g      = 1'b0;
        w_e      = 1'b0;
        w_l      = 1'b0;
        w_err    = 1'b0;
        w_is_mul = 1'b0;
        w_fa     = '0;
        w_fb     = '0;
        if (r_mode) begin
            case (int'(r_cmd))
                0: begin
                    w_arith = w_ext_a + w_ext_b;
                    w_cout  = w_arith[WIDTH];
                    w_oflow = (r_opa[WIDTH-1] == r_opb[WIDTH-1]) && (w_arith[WIDTH-1] != r_opa[WIDTH-1]);
                end
                1: begin
                    w_arith = w_ext_a - w_ext_b;
                    w_cout  = w_arith[WIDTH];
                    w_oflow = (r_opa[WIDTH-1] != r_opb[WIDTH-1]) && (w_arith[WIDTH-1] != r_opa[WIDTH-1]);
                end
                2: begin
                    w_arith = w_ext_a + w_ext_b + w_ext_cin;
                    w_cout  = w_arith[WIDTH];
                end
                3: begin
                    // Zero-extended difference goes negative exactly on borrow.
                    w_arith = w_ext_a - w_ext_b - w_ext_cin;
                    w_cout  = w_arith[WIDTH];
                end
                4: w_arith = w_ext_a + ONE;
                5: w_arith = w_ext_a - ONE;
                6: w_arith = w_ext_b + ONE;
                7: w_arith = w_ext_b - ONE;
                8: begin
                    w_g = r_opa > r_opb;
                    w_e = r_opa == r_opb;
                    w_l = r_opa < r_opb;
                end
                9: begin
                    w_is_mul = 1'b1;
                    w_fa     = w_ext_a + ONE;
                    w_fb     = w_ext_b + ONE;
                end
                10: begin
                    w_is_mul = 1'b1;
                    w_fa     = {r_opa, 1'b0};
                    w_fb     = w_ext_b;
                end
                default: w_err = 1'b1;
            endcase
            w_res = {{(WIDTH-1){1'b0}}, w_arith};
        end else begin
            case (int'(r_cmd))
                0:  w_log = r_opa & r_opb;
                1:  w_log = ~(r_opa & r_opb);
                2:  w_log = r_opa | r_opb;
                3:  w_log = ~(r_opa | r_opb);
                4:  w_log = r_opa ^ r_opb;
                5:  w_log = ~(r_opa ^ r_opb);
                6:  w_log = ~r_opa;
                7:  w_log = ~r_opb;
                8:  w_log = r_opa >> 1;
                9:  w_log = r_opa << 1;
                10: w_log = r_opb >> 1;
                11: w_log = r_opb << 1;
                12: begin
                    w_log = WIDTH'(({r_opa, r_opa} << w_amt) >> WIDTH);
                    w_err = |(r_opb >> SH_W);
                end
                13: begin
                    w_log = WIDTH'({r_opa, r_opa} >> w_amt);
                    w_err = |(r_opb >> SH_W);
                end
                default: w_err = 1'b1;
            endcase
            w_res = {{WIDTH{1'b0}}, w_log};
        end
    end

    // NOTE: every register, operands included, is cleared by the asynchronous
    // reset so an aborted operation leaves nothing stale behind; state updates
    // use non-blocking assignments only.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_cmd       <= '0;
            r_mode      <= 1'b0;
            r_cin       <= 1'b0;
            r_have_a    <= 1'b0;
            r_fa        <= '0;
            r_fb        <= '0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_cout      <= 1'b0;
            r_oflow     <= 1'b0;
            r_g         <= 1'b0;
            r_e         <= 1'b0;
            r_l         <= 1'b0;
            r_err       <= 1'b0;
        end else if (!CE) begin
            r_res_valid <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_all_in || w_partial) begin
                        if (INP_VALID[0]) r_opa <= OPA;
                        if (INP_VALID[1]) r_opb <= OPB;
                        r_have_a <= INP_VALID[0];
                        r_cmd    <= CMD;
                        r_mode   <= MODE;
                        r_cin    <= CIN;
                        r_cnt    <= '0;
                        r_state  <= w_all_in ? S_EXEC : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_arrive) begin
                        if (r_have_a) r_opb <= OPB;
                        else          r_opa <= OPA;
                        r_state <= S_EXEC;
                    end else if (r_cnt == LAST) begin
                        r_res       <= '0;
                        r_err       <= 1'b1;
                        {r_cout, r_oflow, r_g, r_e, r_l} <= '0;
                        r_res_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_is_mul) begin
                        r_fa    <= w_fa;
                        r_fb    <= w_fb;
                        r_state <= S_MUL2;
                    end else begin
                        r_res       <= w_res;
                        r_cout      <= w_cout;
                        r_oflow     <= w_oflow;
                        r_g         <= w_g;
                        r_e         <= w_e;
                        r_l         <= w_l;
                        r_err       <= w_err;
                        r_res_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                S_MUL2: begin
                    r_res       <= w_prod;
                    {r_cout, r_oflow, r_g, r_e, r_l, r_err} <= '0;
                    r_res_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign RES       = r_res;
    assign RES_VALID = r_res_valid;
    assign COUT      = r_cout;
    assign OFLOW     = r_oflow;
    assign G         = r_g;
    assign E         = r_e;
    assign L         = r_l;
    assign ERR       = r_err;
    assign BUSY      = (r_state != S_IDLE);

endmodule
